// File: rtl/occ_lookup_arbiter_pkg.sv
// Shared widths, arbiter state encoding and Occ result bundle for the seek datapath.
// Pure declarations: no latency, no flow control.
package occ_lookup_arbiter_pkg;

  localparam int KLS_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } arb_state_t;

  // One Occ value per nucleotide symbol (A, C, G, T).
  typedef logic [3:0][KLS_W-1:0] occ_vals_t;

endpackage

// File: rtl/occ_lookup_arbiter_rr_pick.sv
// Combinational round-robin picker: first set pending bit after last_grant, wrapping.
// Zero latency; valid low when nothing is pending.
module occ_lookup_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [ID_W-1:0]  last_grant,
  output logic [ID_W-1:0]  grant,
  output logic             valid
);

  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    valid = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(last_grant) + off) % N_REQ;
      if (!valid && pending[idx]) begin
        valid = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/occ_lookup_arbiter.sv
// Shares one Occ lookup engine among N_REQ requesters, round-robin, one lookup in flight.
// Request to occ_start is 2 cycles, engine result to req_val_valid is 1; busy requesters' pulses are dropped and flagged.
module occ_lookup_arbiter
  import occ_lookup_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int KW    = KLS_W,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0][KW-1:0]       req_k,
  input  logic [N_REQ-1:0][KW-1:0]       req_ks,
  input  logic [N_REQ-1:0]               req_start,
  output logic [N_REQ-1:0][3:0][KW-1:0]  req_val_k,
  output logic [N_REQ-1:0][3:0][KW-1:0]  req_val_ks,
  output logic [N_REQ-1:0]               req_val_valid,
  output logic [KW-1:0]                  occ_k,
  output logic [KW-1:0]                  occ_ks,
  output logic                           occ_start,
  input  logic [3:0][KW-1:0]             occ_val_k,
  input  logic [3:0][KW-1:0]             occ_val_ks,
  input  logic                           occ_val_valid,
  output logic                           busy,
  output logic [N_REQ-1:0]               err_overrun,
  output logic                           err_spurious,
  output logic [31:0]                    lookup_cnt
);

  arb_state_t               state_q, state_d;
  logic [N_REQ-1:0]         pending_q;
  logic [N_REQ-1:0]         req_busy;
  logic [N_REQ-1:0]         capture;
  logic [N_REQ-1:0]         grant_mask;
  logic [N_REQ-1:0][KW-1:0] slot_k_q, slot_ks_q;
  logic [ID_W-1:0]          owner_q, last_grant_q, pick_idx;
  logic                     pick_vld;
  logic                     grant_now;
  logic                     result_now;

  occ_lookup_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .pending    (pending_q),
    .last_grant (last_grant_q),
    .grant      (pick_idx),
    .valid      (pick_vld)
  );

  // The owner counts as busy until its lookup returns, so it cannot queue a second one.
  always_comb begin
    req_busy = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_busy[i] = pending_q[i] | ((state_q != S_IDLE) && (owner_q == ID_W'(i)));
    end
  end

  assign capture    = req_start & ~req_busy;
  assign grant_now  = (state_q == S_IDLE) && pick_vld;
  assign result_now = (state_q == S_WAIT) && occ_val_valid;
  assign busy       = (state_q != S_IDLE) || (|pending_q);

  always_comb begin
    grant_mask = '0;
    if (grant_now) grant_mask[pick_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    occ_start = 1'b0;
    case (state_q)
      S_IDLE:  if (pick_vld) state_d = S_ISSUE;
      S_ISSUE: begin
        occ_start = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT:  if (occ_val_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q     <= '0;
      slot_k_q      <= '0;
      slot_ks_q     <= '0;
      owner_q       <= '0;
      last_grant_q  <= ID_W'(N_REQ - 1);
      occ_k         <= '0;
      occ_ks        <= '0;
      req_val_k     <= '0;
      req_val_ks    <= '0;
      req_val_valid <= '0;
      err_overrun   <= '0;
      err_spurious  <= 1'b0;
      lookup_cnt    <= '0;
    end else begin
      req_val_valid <= '0;
      pending_q     <= (pending_q & ~grant_mask) | capture;

      for (int i = 0; i < N_REQ; i++) begin
        if (capture[i]) begin
          slot_k_q[i]  <= req_k[i];
          slot_ks_q[i] <= req_ks[i];
        end
        if (req_start[i] && req_busy[i]) err_overrun[i] <= 1'b1;
      end

      if (grant_now) begin
        owner_q <= pick_idx;
        occ_k   <= slot_k_q[pick_idx];
        occ_ks  <= slot_ks_q[pick_idx];
      end

      if (result_now) begin
        req_val_k[owner_q]     <= occ_val_k;
        req_val_ks[owner_q]    <= occ_val_ks;
        req_val_valid[owner_q] <= 1'b1;
        last_grant_q           <= owner_q;
        lookup_cnt             <= lookup_cnt + 32'd1;
      end

      if (occ_val_valid && (state_q != S_WAIT)) err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_occ_lookup_arbiter.sv
// Bench for occ_lookup_arbiter: random and directed traffic against a behavioural model.
// Engine stub answers each occ_start after a random 1..5 cycle delay unless driven by hand.
module tb_occ_lookup_arbiter;
  import occ_lookup_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int KW = KLS_W;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [N-1:0][KW-1:0]       req_k, req_ks;
  logic [N-1:0]               req_start;
  logic [N-1:0][3:0][KW-1:0]  req_val_k, req_val_ks;
  logic [N-1:0]               req_val_valid;
  logic [KW-1:0]              occ_k, occ_ks;
  logic                       occ_start;
  logic [3:0][KW-1:0]         occ_val_k, occ_val_ks;
  logic                       occ_val_valid;
  logic                       busy;
  logic [N-1:0]               err_overrun;
  logic                       err_spurious;
  logic [31:0]                lookup_cnt;

  occ_lookup_arbiter #(.N_REQ(N), .KW(KW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_k         (req_k),
    .req_ks        (req_ks),
    .req_start     (req_start),
    .req_val_k     (req_val_k),
    .req_val_ks    (req_val_ks),
    .req_val_valid (req_val_valid),
    .occ_k         (occ_k),
    .occ_ks        (occ_ks),
    .occ_start     (occ_start),
    .occ_val_k     (occ_val_k),
    .occ_val_ks    (occ_val_ks),
    .occ_val_valid (occ_val_valid),
    .busy          (busy),
    .err_overrun   (err_overrun),
    .err_spurious  (err_spurious),
    .lookup_cnt    (lookup_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: requests waiting, the one lookup in flight, and result banks.
  bit   [N-1:0]              m_pend;
  logic [N-1:0][KW-1:0]      m_sk, m_sks;
  int                        m_lg, m_owner;
  bit                        m_active, m_issue;
  logic [KW-1:0]             m_ok, m_oks;
  logic [N-1:0][3:0][KW-1:0] m_rvk, m_rvks;
  bit   [N-1:0]              m_rvv, m_ovr;
  bit                        m_spur;
  logic [31:0]               m_cnt;

  bit auto_eng = 1'b0;
  int eng_cnt  = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_sk = '0; m_sks = '0; m_lg = N - 1; m_owner = 0;
    m_active = 1'b0; m_issue = 1'b0; m_ok = '0; m_oks = '0;
    m_rvk = '0; m_rvks = '0; m_rvv = '0; m_ovr = '0; m_spur = 1'b0; m_cnt = '0;
  endtask

  task automatic model_step();
    bit [N-1:0] busy_v;
    bit act0, iss0;
    int own0;
    act0 = m_active; iss0 = m_issue; own0 = m_owner;
    for (int i = 0; i < N; i++) busy_v[i] = m_pend[i] || (act0 && own0 == i);
    m_rvv = '0;
    if (act0 && !iss0) begin
      if (occ_val_valid) begin
        m_rvk[own0]  = occ_val_k;
        m_rvks[own0] = occ_val_ks;
        m_rvv[own0]  = 1'b1;
        m_lg         = own0;
        m_cnt        = m_cnt + 1;
        m_active     = 1'b0;
      end
    end else if (occ_val_valid) begin
      m_spur = 1'b1;
    end
    if (act0 && iss0) m_issue = 1'b0;
    if (!act0) begin
      for (int off = 1; off <= N; off++) begin
        int j;
        j = (m_lg + off) % N;
        if (m_pend[j]) begin
          m_owner = j; m_active = 1'b1; m_issue = 1'b1;
          m_ok = m_sk[j]; m_oks = m_sks[j]; m_pend[j] = 1'b0;
          break;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (req_start[i]) begin
        if (busy_v[i]) m_ovr[i] = 1'b1;
        else begin
          m_sk[i] = req_k[i]; m_sks[i] = req_ks[i]; m_pend[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare();
    chk("occ_start",     512'(occ_start),     512'(m_active && m_issue));
    chk("occ_k",         512'(occ_k),         512'(m_ok));
    chk("occ_ks",        512'(occ_ks),        512'(m_oks));
    chk("req_val_valid", 512'(req_val_valid), 512'(m_rvv));
    chk("req_val_k",     512'(req_val_k),     512'(m_rvk));
    chk("req_val_ks",    512'(req_val_ks),    512'(m_rvks));
    chk("busy",          512'(busy),          512'(m_active || (|m_pend)));
    chk("err_overrun",   512'(err_overrun),   512'(m_ovr));
    chk("err_spurious",  512'(err_spurious),  512'(m_spur));
    chk("lookup_cnt",    512'(lookup_cnt),    512'(m_cnt));
  endtask

  // One clock: model follows the edge, outputs checked at negedge, then next inputs set up.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
    compare();
    req_start     = '0;
    occ_val_valid = 1'b0;
    if (auto_eng) begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          occ_val_valid = 1'b1;
          for (int s = 0; s < 4; s++) begin
            occ_val_k[s]  = $urandom;
            occ_val_ks[s] = $urandom;
          end
        end
      end
      if (occ_start) eng_cnt = $urandom_range(1, 5);
    end
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1; req_start = '0; occ_val_valid = 1'b0; eng_cnt = 0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_issue(input int budget, output logic [KW-1:0] k);
    bit seen;
    seen = 1'b0;
    k    = '0;
    for (int c = 0; c < budget && !seen; c++) begin
      tick();
      if (occ_start) begin
        seen = 1'b1;
        k    = occ_k;
      end
    end
    if (!seen) begin
      n_checks++; n_errors++;
      $display("FAIL wait_issue: no occ_start within %0d cycles", budget);
    end
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (busy && c < budget) begin
      tick();
      c++;
    end
    if (busy) begin
      n_checks++; n_errors++;
      $display("FAIL drain: still busy after %0d cycles", budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [KW-1:0] k;
    occ_vals_t     e_k, e_ks;
    int            n_iss;
    logic [KW-1:0] first_k;
    int            seq[$];

    rst = 1'b1; req_k = '0; req_ks = '0; req_start = '0;
    occ_val_k = '0; occ_val_ks = '0; occ_val_valid = 1'b0;
    model_reset();
    tick();
    tick();
    chk("reset_cnt",  512'(lookup_cnt), 512'(0));
    chk("reset_busy", 512'(busy),       512'(0));
    chk("reset_errs", 512'({err_overrun, err_spurious}), 512'(0));
    rst = 1'b0;

    // Single request, hand-timed engine.
    auto_eng  = 1'b0;
    req_k[2]  = 32'h10;
    req_ks[2] = 32'h18;
    req_start = 4'b0100;
    tick();
    chk("single_c1_no_start", 512'(occ_start), 512'(0));
    tick();
    chk("single_c2_start", 512'(occ_start), 512'(1));
    chk("single_c2_k",     512'(occ_k),     512'(32'h10));
    chk("single_c2_ks",    512'(occ_ks),    512'(32'h18));
    repeat (5) tick();
    e_k  = {32'd4, 32'd3, 32'd2, 32'd1};
    e_ks = {32'd8, 32'd7, 32'd6, 32'd5};
    occ_val_k = e_k; occ_val_ks = e_ks; occ_val_valid = 1'b1;
    tick();
    chk("single_c8_valid", 512'(req_val_valid), 512'(4'b0100));
    chk("single_c8_val_k", 512'(req_val_k[2]),  512'(e_k));
    chk("single_c8_val_ks",512'(req_val_ks[2]), 512'(e_ks));
    chk("single_c8_cnt",   512'(lookup_cnt),    512'(1));
    tick();
    chk("single_c9_valid", 512'(req_val_valid), 512'(0));

    // Simultaneous requests from all four.
    do_reset();
    auto_eng = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_k[i]  = KW'(32'h100 * (i + 1));
      req_ks[i] = KW'(32'h100 * (i + 1) + 8);
    end
    req_start = '1;
    for (int j = 0; j < N; j++) begin
      wait_issue(40, k);
      chk($sformatf("simul_order_%0d", j), 512'(k), 512'(32'h100 * (j + 1)));
    end
    drain(40);
    chk("simul_cnt",     512'(lookup_cnt),  512'(4));
    chk("simul_overrun", 512'(err_overrun), 512'(0));

    // Rotation: after 1 is served, 3 beats 0.
    do_reset();
    req_k[1] = 32'h111; req_start = 4'b0010;
    wait_issue(20, k);
    chk("rot_first", 512'(k), 512'(32'h111));
    drain(20);
    req_k[0] = 32'hA0; req_k[3] = 32'hA3; req_start = 4'b1001;
    wait_issue(20, k);
    chk("rot_3_before_0", 512'(k), 512'(32'hA3));
    wait_issue(20, k);
    chk("rot_then_0", 512'(k), 512'(32'hA0));
    drain(20);

    // Overrun: second pulse from 1 while its lookup is still owned.
    do_reset();
    req_k[1] = 32'h11; req_ks[1] = 32'h19; req_start = 4'b0010;
    n_iss = 0; first_k = '0;
    tick();
    tick();
    if (occ_start) begin n_iss++; first_k = occ_k; end
    req_k[1] = 32'h99; req_ks[1] = 32'h9F; req_start = 4'b0010;
    repeat (30) begin
      tick();
      if (occ_start) begin
        if (n_iss == 0) first_k = occ_k;
        n_iss++;
      end
    end
    chk("overrun_issues",  512'(n_iss),       512'(1));
    chk("overrun_k",       512'(first_k),     512'(32'h11));
    chk("overrun_flag",    512'(err_overrun), 512'(4'b0010));

    // Spurious result while idle.
    auto_eng = 1'b0;
    occ_val_valid = 1'b1;
    tick();
    chk("spur_flag",  512'(err_spurious),  512'(1));
    chk("spur_valid", 512'(req_val_valid), 512'(0));
    chk("spur_cnt",   512'(lookup_cnt),    512'(1));

    // Async reset in the middle of a lookup, with requester 0 queued behind it.
    do_reset();
    req_k[1] = 32'h200; req_start = 4'b0010;
    tick();
    tick();
    req_k[0] = 32'h300; req_start = 4'b0001;
    tick();
    tick();
    chk("areset_pre_busy", 512'(busy), 512'(1));
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("areset_occ_start", 512'(occ_start), 512'(0));
    chk("areset_occ_k",     512'({occ_k, occ_ks}), 512'(0));
    chk("areset_busy",      512'(busy), 512'(0));
    chk("areset_outs",      512'({req_val_valid, err_overrun, err_spurious, lookup_cnt}), 512'(0));
    tick();
    rst = 1'b0;
    auto_eng = 1'b1; eng_cnt = 0;
    req_k[3] = 32'h400; req_start = 4'b1000;
    wait_issue(20, k);
    chk("areset_serve_3", 512'(k), 512'(32'h400));
    drain(20);
    chk("areset_cnt", 512'(lookup_cnt), 512'(1));

    // Randomised traffic.
    do_reset();
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        req_k[i]     = $urandom;
        req_ks[i]    = $urandom;
        req_start[i] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 63) == 0) req_start = '1;
      tick();
    end
    drain(100);

    // Fairness with every requester pulsing continuously.
    for (int i = 0; i < N; i++) req_k[i] = KW'(i);
    for (int c = 0; c < 600 && seq.size() < 12; c++) begin
      req_start = '1;
      tick();
      if (occ_start) seq.push_back(int'(occ_k));
    end
    chk("fair_grants", 512'(seq.size()), 512'(12));
    for (int j = 1; j < seq.size(); j++)
      chk($sformatf("fair_rr_%0d", j), 512'(seq[j]), 512'((seq[j-1] + 1) % N));
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/occ_lookup_arbiter.md
Name: occ_lookup_arbiter

Overview:
- Shares one occurrence-lookup engine (AXI4-Lite Occ reader) among N_REQ extension requesters, e.g. several parallel bidirectional SMEM seek engines.
- Captures each requester's (k, ks) lookup pulse and grants the engine round-robin, one lookup outstanding at a time.
- Routes the eight returned Occ values back to the owning requester.
- Sits between the Extension instances and the single OccLookup instance.

Parameters:
N_REQ, 4, number of requesters (2..16)
KW, KLS_W (package), width of k/ks/occ values
ID_W, $clog2(N_REQ), owner index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_k  in  [N_REQ][KW]  per-requester k
req_ks  in  [N_REQ][KW]  per-requester k+s
req_start  in  [N_REQ]  one-cycle lookup request pulse
req_val_k  out  [N_REQ][4][KW]  Occ(k) per symbol, registered
req_val_ks  out  [N_REQ][4][KW]  Occ(k+s) per symbol, registered
req_val_valid  out  [N_REQ]  one-cycle result pulse per requester
occ_k  out  KW  to engine
occ_ks  out  KW  to engine
occ_start  out  1  engine start pulse
occ_val_k  in  [4][KW]  engine result
occ_val_ks  in  [4][KW]  engine result
occ_val_valid  in  1  engine result pulse
busy  out  1  state != S_Idle or any request pending
err_overrun  out  [N_REQ]  sticky flag: request while already busy
err_spurious  out  1  sticky flag: result while not in S_Wait
lookup_cnt  out  32  completed lookups, wraps at 2^32

Behaviour:
- Reset (async, all flops):
  - state = S_Idle; pending = 0; owner = 0; last_grant = N_REQ-1, so requester 0 wins first.
  - All outputs 0, including occ_k/occ_ks, req_val_* and the error flags.
- Capture: req_start[i] with req_busy[i]=0 latches req_k[i]/req_ks[i] into slot i and sets pending[i] next cycle.
  - req_busy[i] = pending[i] | (state != S_Idle & owner == i).
  - req_start[i] with req_busy[i]=1: pulse ignored, slot data kept, err_overrun[i] set.
- S_Idle:
  - If pending != 0: select the first set bit scanning last_grant+1, +2, … modulo N_REQ.
  - Register owner; load occ_k/occ_ks from that slot; clear pending[owner]; go S_Issue.
- S_Issue: occ_start = 1 for exactly this cycle; go S_Wait.
- S_Wait:
  - Hold occ_k/occ_ks stable.
  - On occ_val_valid: register values into req_val_*[owner]; pulse req_val_valid[owner] the next cycle; last_grant <= owner; lookup_cnt += 1; go S_Idle.
  - No timeout.
- occ_start is a combinational decode of state == S_Issue. All other outputs are registered.
- Latency, request pulse at cycle 0 with idle arbiter:
  - pending at 1; grant at 1 -> S_Issue at 2, occ_start high at 2.
  - Engine result at t -> req_val_valid at t+1.
  - Re-arbitration starts at t+1, so occ_start again at t+2 at the earliest.
- Simultaneous pulses: all captured in the same cycle; served in round-robin order.
- A new request from i arriving in the same cycle as i's req_val_valid is legal: by then state is S_Idle, so req_busy[i]=0.
- occ_val_valid outside S_Wait: ignored, err_spurious set. No requester output changes.
- req_val_k/req_val_ks of a non-owner keep their last value. Only the owner's bank updates.
- Reset mid-lookup: the lookup is abandoned. The engine shares rst, so no late result is expected; any late result is flagged spurious.
- Fairness: with all N_REQ requesters continuously pending, each is granted exactly once per N_REQ lookups.

Decomposition:
- Package BwaMemDefines: KLS_W; enum ArbState {S_Idle, S_Issue, S_Wait}; typedef OccVals (4×KLS_W array) shared with Extension/OccLookup.
- Sub-module rr_pick (combinational round-robin priority encoder):
  - Inputs: pending vector and last_grant.
  - Outputs: grant index and valid.
  - Reusable by future arbiters.

Test Plan:
- Single request: req_start[2] with k=0x10, ks=0x18.
  - occ_start at cycle 2 with occ_k=0x10, occ_ks=0x18.
  - Engine returns val_k={1,2,3,4} at cycle 7 -> req_val_valid=4'b0100 at cycle 8 carrying {1,2,3,4}; lookup_cnt=1.
- Simultaneous: all four req_start in the same cycle after reset.
  - Grant order 0,1,2,3.
  - Each req_val_valid arrives one cycle after the matching engine result.
  - lookup_cnt=4; err_overrun=0.
- Rotation: requester 1 served; then requesters 0 and 3 pulse together -> grant 3 before 0.
- Overrun: req_start[1] twice, 2 cycles apart, while 1 is still pending.
  - err_overrun=4'b0010.
  - Exactly one occ_start for 1, with the first k/ks.
- Spurious: occ_val_valid pulsed in S_Idle -> err_spurious=1, req_val_valid stays 0, lookup_cnt unchanged.
- Async reset asserted mid-S_Wait, off-clock-edge:
  - All outputs 0 immediately.
  - After release, req_start[3] is served normally and requester 0's stale pending is gone.
